// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle integer multiply/divide unit with architectural
// HI/LO registers.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   start        request an operation (taken only while busy=0)
//   op[1:0]      0=MULT, 1=MULTU, 2=DIV, 3=DIVU
//   X, Y         32-bit operands, latched in the accept cycle
//   hi_we, lo_we MTHI/MTLO write enables (honoured only when idle and no start)
//   wdata        MTHI/MTLO write data
//   HI, LO       architectural result registers
//   busy         operation in flight (MUL, DIV, FIX states)
//   done         one-cycle pulse, HI/LO already hold the new result
//   div_by_zero  valid with done; divide with Y=0
module muldiv_unit #(
   parameter int MUL_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] X,
   input  logic [31:0] Y,
   input  logic        hi_we,
   input  logic        lo_we,
   input  logic [31:0] wdata,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic        busy,
   output logic        done,
   output logic        div_by_zero
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_MUL  = 3'd1,
      S_DIV  = 3'd2,
      S_FIX  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   localparam logic [5:0] MUL_LAST = 6'(MUL_CYCLES - 1);
   localparam logic [5:0] DIV_LAST = 6'd31;

   state_t      state_r, state_s;
   logic [1:0]  op_r;
   logic [31:0] x_r, y_r;
   logic [31:0] rem_r, quo_r, dvs_r;
   logic        neg_q_r, neg_rem_r;
   logic [5:0]  cnt_r;
   logic [31:0] hi_r, lo_r;
   logic        busy_r, done_r, dbz_r;

   logic        accept_s, is_div_s, y_zero_s, div_signed_s;
   logic [63:0] x_ext_s, y_ext_s, prod_s;
   logic [32:0] shifted_s, trial_s;

   function automatic logic [31:0] neg32(input logic [31:0] v);
      return ~v + 32'd1;
   endfunction

   function automatic logic [31:0] mag32(input logic [31:0] v, input logic signed_op);
      return (signed_op && v[31]) ? neg32(v) : v;
   endfunction

   assign accept_s     = start && ((state_r == S_IDLE) || (state_r == S_DONE));
   assign is_div_s     = op[1];
   assign y_zero_s     = (Y == 32'd0);
   assign div_signed_s = ~op[0];

   // Operands extended to 64 bits; the low 64 bits of the product are exact
   // for both signed and unsigned interpretations.
   assign x_ext_s = op_r[0] ? {32'd0, x_r} : {{32{x_r[31]}}, x_r};
   assign y_ext_s = op_r[0] ? {32'd0, y_r} : {{32{y_r[31]}}, y_r};
   assign prod_s  = x_ext_s * y_ext_s;

   // Restoring divide step: bring in the next dividend bit and trial-subtract.
   assign shifted_s = {rem_r, quo_r[31]};
   assign trial_s   = shifted_s - {1'b0, dvs_r};

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         S_IDLE, S_DONE: begin
            if (!accept_s) begin
               state_s = S_IDLE;
            end else if (!is_div_s) begin
               state_s = S_MUL;
            end else if (y_zero_s) begin
               state_s = S_DONE;
            end else begin
               state_s = S_DIV;
            end
         end
         S_MUL: begin
            if (cnt_r == MUL_LAST) begin
               state_s = S_DONE;
            end else begin
               state_s = S_MUL;
            end
         end
         S_DIV: begin
            if (cnt_r == DIV_LAST) begin
               state_s = S_FIX;
            end else begin
               state_s = S_DIV;
            end
         end
         S_FIX:   state_s = S_DONE;
         default: state_s = S_IDLE;
      endcase
   end

   // Operand capture, iteration datapath and HI/LO register updates.
   always_ff @(posedge clk) begin
      if (rst) begin
         op_r      <= 2'd0;
         x_r       <= 32'd0;
         y_r       <= 32'd0;
         rem_r     <= 32'd0;
         quo_r     <= 32'd0;
         dvs_r     <= 32'd0;
         neg_q_r   <= 1'b0;
         neg_rem_r <= 1'b0;
         cnt_r     <= 6'd0;
         hi_r      <= 32'd0;
         lo_r      <= 32'd0;
      end else begin
         case (state_r)
            S_IDLE, S_DONE: begin
               if (accept_s) begin
                  // A start wins over MTHI/MTLO in the same cycle.
                  op_r      <= op;
                  x_r       <= X;
                  y_r       <= Y;
                  cnt_r     <= 6'd0;
                  rem_r     <= 32'd0;
                  quo_r     <= mag32(X, div_signed_s);
                  dvs_r     <= mag32(Y, div_signed_s);
                  neg_q_r   <= div_signed_s && (X[31] ^ Y[31]);
                  neg_rem_r <= div_signed_s && X[31];
                  if (is_div_s && y_zero_s) begin
                     hi_r <= X;
                     lo_r <= 32'hFFFF_FFFF;
                  end
               end else begin
                  if (hi_we) begin
                     hi_r <= wdata;
                  end
                  if (lo_we) begin
                     lo_r <= wdata;
                  end
               end
            end
            S_MUL: begin
               if (cnt_r == MUL_LAST) begin
                  cnt_r <= 6'd0;
                  hi_r  <= prod_s[63:32];
                  lo_r  <= prod_s[31:0];
               end else begin
                  cnt_r <= cnt_r + 6'd1;
               end
            end
            S_DIV: begin
               cnt_r <= (cnt_r == DIV_LAST) ? 6'd0 : cnt_r + 6'd1;
               if (!trial_s[32]) begin
                  rem_r <= trial_s[31:0];
                  quo_r <= {quo_r[30:0], 1'b1};
               end else begin
                  rem_r <= shifted_s[31:0];
                  quo_r <= {quo_r[30:0], 1'b0};
               end
            end
            S_FIX: begin
               // Quotient takes the XOR of signs, remainder the dividend sign.
               lo_r <= neg_q_r   ? neg32(quo_r) : quo_r;
               hi_r <= neg_rem_r ? neg32(rem_r) : rem_r;
            end
            default: begin
               cnt_r <= 6'd0;
            end
         endcase
      end
   end

   // Status outputs registered from the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_r <= 1'b0;
         done_r <= 1'b0;
         dbz_r  <= 1'b0;
      end else begin
         busy_r <= (state_s == S_MUL) || (state_s == S_DIV) || (state_s == S_FIX);
         done_r <= (state_s == S_DONE);
         dbz_r  <= accept_s && is_div_s && y_zero_s;
      end
   end

   assign HI          = hi_r;
   assign LO          = lo_r;
   assign busy        = busy_r;
   assign done        = done_r;
   assign div_by_zero = dbz_r;

endmodule
